// File: rtl/syscon_pkg.sv
// Shared types and defaults for the system clock/reset controller.
// Holds the state encoding, the counter width and the parameter defaults.
package syscon_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      STRETCH = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int CNT_W            = 8;
   localparam int SYNC_STAGES_DEF  = 2;
   localparam int RESET_CYCLES_DEF = 31;
   localparam int USE_BUFG_DEF     = 0;

endpackage

// File: rtl/bufg.sv
// Behavioural stand-in for the Xilinx BUFG primitive, for simulation and lint.
// Leave this file out of the build when the vendor unisim library supplies BUFG.
module BUFG (
   input  logic I,
   output logic O
);

   assign O = I;

endmodule

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module reset_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_rst
);

   // Declaration value gives the all-ones power-up state after configuration.
   logic [STAGES-1:0] r_sync = '1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], 1'b0};
      end
   end

   assign o_rst = r_sync[STAGES-1];

endmodule

// File: rtl/system_controller_xilinx.sv
// Board clock/reset to SoC clock/reset: synchronized, stretched reset release
// with asynchronous assertion, and optional BUFG on the distributed clock.
module system_controller_xilinx
   import syscon_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int RESET_CYCLES = RESET_CYCLES_DEF,
   parameter int USE_BUFG     = USE_BUFG_DEF
) (
   input  logic clk_sys_i,
   input  logic rst_sys_i,
   output logic clk_i,
   output logic rst_i,
   output logic nrst_i
);

   localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(RESET_CYCLES);

   logic             w_sync_rst;
   state_t           w_state_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Declaration values are the power-up state after configuration.
   state_t           r_state = ASSERT;
   logic [CNT_W-1:0] r_cnt   = '0;
   logic             r_rst   = 1'b1;
   logic             r_nrst  = 1'b0;

   reset_sync #(
      .STAGES (SYNC_STAGES)
   ) u_reset_sync (
      .i_clk (clk_sys_i),
      .i_rst (rst_sys_i),
      .o_rst (w_sync_rst)
   );

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_sync_rst) begin
         w_cnt_next = '0;
      end else if (r_cnt < LP_LIMIT) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   // Decoding on the next count lets the output flop fall on the very edge
   // the count reaches its limit, keeping rst_i a pure register output.
   always_comb begin
      w_state_next = r_state;
      if (w_sync_rst) begin
         w_state_next = ASSERT;
      end else begin
         case (r_state)
            ASSERT, STRETCH: w_state_next = (w_cnt_next >= LP_LIMIT) ? RUN : STRETCH;
            RUN:             w_state_next = RUN;
            default:         w_state_next = ASSERT;
         endcase
      end
   end

   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         r_state <= ASSERT;
         r_cnt   <= '0;
         r_rst   <= 1'b1;
         r_nrst  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_rst   <= (w_state_next != RUN);
         r_nrst  <= (w_state_next == RUN);
      end
   end

   assign rst_i  = r_rst;
   assign nrst_i = r_nrst;

   generate
      if (USE_BUFG != 0) begin : g_bufg
         BUFG u_bufg (
            .I (clk_sys_i),
            .O (clk_i)
         );
      end else begin : g_wire
         assign clk_i = clk_sys_i;
      end
   endgenerate

endmodule

// File: tb/tb_system_controller_xilinx.sv
// Directed bench for system_controller_xilinx: default build plus SYNC_STAGES=3,
// RESET_CYCLES=1 builds with and without BUFG, all sharing one clock and reset.
module tb_system_controller_xilinx;

   logic clk;
   logic rst;

   logic clk0, rst0, nrst0;
   logic clk1, rst1, nrst1;
   logic clk2, rst2, nrst2;

   int n_total = 0;
   int n_bad   = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial rst = 1'b0;

   // ---------------- DUTs ----------------
   system_controller_xilinx u_dut0 (
      .clk_sys_i (clk),
      .rst_sys_i (rst),
      .clk_i     (clk0),
      .rst_i     (rst0),
      .nrst_i    (nrst0)
   );

   system_controller_xilinx #(
      .SYNC_STAGES  (3),
      .RESET_CYCLES (1),
      .USE_BUFG     (0)
   ) u_dut1 (
      .clk_sys_i (clk),
      .rst_sys_i (rst),
      .clk_i     (clk1),
      .rst_i     (rst1),
      .nrst_i    (nrst1)
   );

   system_controller_xilinx #(
      .SYNC_STAGES  (3),
      .RESET_CYCLES (1),
      .USE_BUFG     (1)
   ) u_dut2 (
      .clk_sys_i (clk),
      .rst_sys_i (rst),
      .clk_i     (clk2),
      .rst_i     (rst2),
      .nrst_i    (nrst2)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic got, input logic exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%b exp=%b at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_d0(input string tag, input logic exp_rst);
      check({tag, " d0.rst"},  rst0,  exp_rst);
      check({tag, " d0.nrst"}, nrst0, ~exp_rst);
   endtask

   task automatic check_d12(input string tag, input logic exp_rst);
      check({tag, " d1.rst"},  rst1,  exp_rst);
      check({tag, " d1.nrst"}, nrst1, ~exp_rst);
      check({tag, " d2.rst"},  rst2,  exp_rst);
      check({tag, " d2.nrst"}, nrst2, ~exp_rst);
   endtask

   task automatic check_clks(input string tag, input logic exp_clk);
      check({tag, " d0.clk"}, clk0, exp_clk);
      check({tag, " d1.clk"}, clk1, exp_clk);
      check({tag, " d2.clk"}, clk2, exp_clk);
   endtask

   // ---------------- driver tasks ----------------
   // Caller has just released rst (or is at power-up); the next rising edge is
   // edge 1. Ends 1 time unit after edge 33.
   task automatic run_sequence(input string tag);
      for (int e = 1; e <= 33; e++) begin
         @(posedge clk);
         #1;
         check_clks({tag, " hi"}, 1'b1);
         if (e == 1)  check_d0 ({tag, " e1"},  1'b1);
         if (e == 3)  check_d12({tag, " e3"},  1'b1);
         if (e == 4)  check_d12({tag, " e4"},  1'b0);
         if (e == 20) check_d0 ({tag, " e20"}, 1'b1);
         if (e == 32) check_d0 ({tag, " e32"}, 1'b1);
         if (e == 33) begin
            check_d0 ({tag, " e33"}, 1'b0);
            check_d12({tag, " e33"}, 1'b0);
         end
         if (e < 33) begin
            @(negedge clk);
            #1;
            check_clks({tag, " lo"}, 1'b0);
         end
      end
   endtask

   task automatic assert_rst(input string tag);
      rst = 1'b1;
      #1;
      check_d0 ({tag, " async"}, 1'b1);
      check_d12({tag, " async"}, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1;
      check_d0 ("pwrup t0", 1'b1);
      check_d12("pwrup t0", 1'b1);
      run_sequence("pwrup");

      // Reset held five cycles, released on a falling edge.
      @(negedge clk);
      assert_rst("hold5");
      repeat (5) @(negedge clk);
      check_d0("hold5 held", 1'b1);
      rst = 1'b0;
      run_sequence("hold5");

      // Re-pulse after ten stretch cycles.
      @(negedge clk);
      assert_rst("repulse a");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_d0("repulse stretch10", 1'b1);
      @(negedge clk);
      assert_rst("repulse b");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_sequence("repulse");

      // 1 ns pulse mid-cycle while running (currently 1 unit after edge 33).
      #1;
      check_d0("short prerun", 1'b0);
      assert_rst("short");
      rst = 1'b0;
      run_sequence("short");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/system_controller_xilinx.md
SYSTEM_CONTROLLER_XILINX -- requirements
Module: system_controller_xilinx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of reset-synchronizer flops; legal range 2..4.
REQ-002 Parameter RESET_CYCLES, default 31: reset-stretch length in clk_sys_i cycles after synchronization; legal range 1..255.
REQ-003 Parameter USE_BUFG, default 0: 1 routes clk_i through a Xilinx BUFG primitive; 0 uses a plain wire.
REQ-004 clk_sys_i  input  1  board system clock; the single clock of the block.
REQ-005 rst_sys_i  input  1  board reset; asynchronous, active-high.
REQ-006 clk_i  output  1  system clock distributed to the SoC.
REQ-007 rst_i  output  1  SoC reset, active-high, synchronous deassertion.
REQ-008 nrst_i  output  1  SoC reset, active-low; always the exact complement of rst_i.
REQ-009 The block SHALL have one clock, clk_sys_i, and one reset, rst_sys_i, which is asynchronous and active-high.

Function
REQ-010 clk_i SHALL equal clk_sys_i with no cycle delay (wire or BUFG per USE_BUFG).
REQ-011 rst_sys_i high SHALL force rst_i=1 and nrst_i=0 immediately (combinationally through async flop set), without waiting for a clock edge.
REQ-012 Deassertion path: SYNC_STAGES-flop synchronizer (async set by rst_sys_i, shifts 0 in) followed by a stretch counter.
REQ-013 Counter width SHALL be 8 bits; counter loads 0 while synchronized reset is high, increments each cycle afterwards, saturates at RESET_CYCLES.
REQ-014 State machine: ASSERT (rst_sys_i high or sync output high) -> STRETCH (counter < RESET_CYCLES) -> RUN; RUN is terminal until rst_sys_i rises.
REQ-015 rst_i SHALL be registered high in ASSERT and STRETCH and low in RUN; it falls only on a rising clk_sys_i edge.
REQ-016 Latency: with edge 1 the first rising edge sampling rst_sys_i low, rst_i SHALL fall after edge SYNC_STAGES+RESET_CYCLES (33 with defaults).
REQ-017 rst_sys_i rising in STRETCH or RUN SHALL return the block to ASSERT immediately and restart the full sequence after release.
REQ-018 A rst_sys_i pulse shorter than one clock period SHALL still produce a full-length reset sequence.
REQ-019 rst_i and nrst_i SHALL be glitch-free (driven directly from flops, no combinational decode).

Reset
REQ-020 All flops SHALL power up (initial value) in the reset state: synchronizer all-ones, counter 0, state ASSERT, rst_i=1.
REQ-021 Without any rst_sys_i pulse after configuration, rst_i SHALL deassert after SYNC_STAGES+RESET_CYCLES clock edges.
REQ-022 rst_sys_i SHALL asynchronously set the synchronizer, clear the counter, and force state ASSERT.

Structure
REQ-023 Package syscon_pkg SHALL hold the state enumeration (ASSERT, STRETCH, RUN), the counter width constant (8), and the parameter defaults.
REQ-024 The synchronizer SHALL be a sub-module named reset_sync (parameter STAGES; async-set, synchronous release).
REQ-025 The top module SHALL contain the stretch counter, the state machine, output registers and the clock buffer selection.

Verification
REQ-026 Power-up, rst_sys_i held 0 -> rst_i=1 through edge 32 and 0 after edge 33; nrst_i complementary throughout.
REQ-027 rst_sys_i high 5 cycles, then low -> rst_i=1 immediately on assertion; falls exactly 33 edges after release.
REQ-028 rst_sys_i re-pulsed at stretch cycle 10 -> rst_i stays 1; counter restarts; fall 33 edges after second release.
REQ-029 rst_sys_i 1 ns pulse mid-cycle in RUN -> rst_i rises asynchronously; full 33-cycle sequence follows.
REQ-030 Parameters SYNC_STAGES=3, RESET_CYCLES=1 -> rst_i falls 4 edges after release; clk_i matches clk_sys_i every edge, USE_BUFG 0 and 1.
